// File: rtl/ace_pkg.sv
// ace_pkg: shared encodings for the ACE snoop responder.
//   - AC snoop-type codes, CR response bit positions, cache update op codes
//   - default request/response structs used by ace_snoop_responder
//   - snoop_known(): true for snoop types this responder decodes
package ace_pkg;

    localparam int ACE_AW = 64;
    localparam int ACE_DW = 64;

    // AC snoop-type encodings
    localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

    // CR response bit indices
    localparam int CR_DT  = 0;  // DataTransfer
    localparam int CR_ERR = 1;  // Error (never set)
    localparam int CR_PD  = 2;  // PassDirty
    localparam int CR_IS  = 3;  // IsShared
    localparam int CR_WU  = 4;  // WasUnique

    typedef enum logic [1:0] {
        UPD_NONE        = 2'd0,
        UPD_CLEAN       = 2'd1,
        UPD_MAKE_SHARED = 2'd2,
        UPD_INVALIDATE  = 2'd3
    } upd_op_e;

    typedef struct packed {
        logic [ACE_AW-1:0] addr;
        logic [3:0]        snoop;
        logic [2:0]        prot;
    } ac_chan_t;

    typedef struct packed {
        logic [ACE_DW-1:0] data;
        logic              last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic       ac_ready;
        logic       cr_valid;
        logic [4:0] cr_resp;
        logic       cd_valid;
        cd_chan_t   cd;
    } snoop_resp_t;

    function automatic logic snoop_known(input logic [3:0] s);
        return (s == SNP_READ_ONCE)   || (s == SNP_READ_SHARED)  ||
               (s == SNP_READ_CLEAN)  || (s == SNP_READ_NSD)     ||
               (s == SNP_READ_UNIQUE) || (s == SNP_CLEAN_SHARED) ||
               (s == SNP_CLEAN_INVALID) || (s == SNP_MAKE_INVALID);
    endfunction

endpackage

// File: rtl/ace_snoop_decode.sv
// ace_snoop_decode: combinational snoop response decode.
//   in : snoop (AC type), hit/dirty/shared (line state from lookup)
//   out: cr_resp (CR response bits), update_op (cache state update to apply)
module ace_snoop_decode
    import ace_pkg::*;
(
    input  logic [3:0] snoop,
    input  logic       hit,
    input  logic       dirty,
    input  logic       shared,
    output logic [4:0] cr_resp,
    output logic [1:0] update_op
);

    always_comb begin
        cr_resp   = '0;
        update_op = UPD_NONE;
        if (hit) begin
            case (snoop)
                SNP_READ_ONCE: begin
                    cr_resp[CR_DT] = 1'b1;
                    cr_resp[CR_IS] = 1'b1;
                end
                SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
                    cr_resp[CR_DT] = 1'b1;
                    cr_resp[CR_PD] = dirty;
                    cr_resp[CR_IS] = 1'b1;
                    update_op      = UPD_MAKE_SHARED;
                end
                SNP_READ_UNIQUE: begin
                    cr_resp[CR_DT] = 1'b1;
                    cr_resp[CR_PD] = dirty;
                    update_op      = UPD_INVALIDATE;
                end
                SNP_CLEAN_SHARED: begin
                    // A clean unique line keeps its unique copy, so it reports
                    // WasUnique alone; dirty or shared lines report IsShared.
                    cr_resp[CR_DT] = dirty;
                    cr_resp[CR_PD] = dirty;
                    cr_resp[CR_IS] = dirty | shared;
                    update_op      = dirty ? UPD_CLEAN : UPD_NONE;
                end
                SNP_CLEAN_INVALID: begin
                    cr_resp[CR_DT] = dirty;
                    cr_resp[CR_PD] = dirty;
                    update_op      = UPD_INVALIDATE;
                end
                SNP_MAKE_INVALID: update_op = UPD_INVALIDATE;
                default: ;
            endcase
            // Unknown snoop types answer with an all-zero response.
            cr_resp[CR_WU] = snoop_known(snoop) & ~shared;
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: services one ACE snoop at a time.
//   clk_i/rst_i       clock, async active-high reset
//   snoop_req_i       AC request, CR/CD ready
//   snoop_resp_o      AC ready, CR response, CD data beats
//   lookup_*          cache lookup request/grant and one-cycle result
//   update_*          cache state update request/grant and op code
// Flow: IDLE -> LOOKUP -> WAIT -> [UPDATE] -> RESP -> [DATA] -> IDLE.
module ace_snoop_responder
    import ace_pkg::*;
#(
    parameter int  AddrWidth    = 64,
    parameter int  DataWidth    = 64,
    parameter int  LineWidth    = 512,
    parameter type snoop_req_t  = ace_pkg::snoop_req_t,
    parameter type snoop_resp_t = ace_pkg::snoop_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  snoop_req_t           snoop_req_i,
    output snoop_resp_t          snoop_resp_o,
    output logic                 lookup_req_o,
    input  logic                 lookup_gnt_i,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_valid_i,
    input  logic                 lookup_hit_i,
    input  logic                 lookup_dirty_i,
    input  logic                 lookup_shared_i,
    input  logic [LineWidth-1:0] lookup_data_i,
    output logic                 update_req_o,
    input  logic                 update_gnt_i,
    output logic [1:0]           update_op_o
);

    localparam int NB  = LineWidth / DataWidth;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int OFS = $clog2(LineWidth / 8);
    localparam logic [AddrWidth-1:0] LINE_MASK = {AddrWidth{1'b1}} << OFS;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WAIT, S_UPDATE, S_RESP, S_DATA
    } state_e;

    state_e               state, state_nx;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic [LineWidth-1:0] line_q;
    logic [4:0]           resp_q;
    logic [1:0]           op_q;
    logic [BW-1:0]        beat_q;
    logic [4:0]           dec_resp;
    logic [1:0]           dec_op;
    logic                 beat_last;

    // Decode runs on the live lookup result; its outputs are captured in WAIT.
    ace_snoop_decode u_decode (
        .snoop     (snoop_q),
        .hit       (lookup_hit_i),
        .dirty     (lookup_dirty_i),
        .shared    (lookup_shared_i),
        .cr_resp   (dec_resp),
        .update_op (dec_op)
    );

    assign beat_last     = (beat_q == BW'(NB - 1));
    assign lookup_addr_o = addr_q & LINE_MASK;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (snoop_req_i.ac_valid) state_nx = S_LOOKUP;
            S_LOOKUP: if (lookup_gnt_i)         state_nx = S_WAIT;
            S_WAIT:   if (lookup_valid_i)
                          state_nx = (dec_op != UPD_NONE) ? S_UPDATE : S_RESP;
            S_UPDATE: if (update_gnt_i)         state_nx = S_RESP;
            S_RESP:   if (snoop_req_i.cr_ready)
                          state_nx = resp_q[CR_DT] ? S_DATA : S_IDLE;
            S_DATA:   if (snoop_req_i.cd_ready && beat_last) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            snoop_q <= '0;
            line_q  <= '0;
            resp_q  <= '0;
            op_q    <= '0;
            beat_q  <= '0;
        end else begin
            if (state == S_IDLE && snoop_req_i.ac_valid) begin
                addr_q  <= AddrWidth'(snoop_req_i.ac.addr);
                snoop_q <= snoop_req_i.ac.snoop;
            end
            if (state == S_WAIT && lookup_valid_i) begin
                line_q <= lookup_data_i;
                resp_q <= dec_resp;
                op_q   <= dec_op;
            end
            if (state == S_DATA && snoop_req_i.cd_ready)
                beat_q <= beat_last ? '0 : beat_q + 1'b1;
        end
    end

    always_comb begin
        snoop_resp_o          = '0;
        // State already reads IDLE during reset, so gate ac_ready explicitly.
        snoop_resp_o.ac_ready = (state == S_IDLE) && !rst_i;
        snoop_resp_o.cr_valid = (state == S_RESP);
        snoop_resp_o.cr_resp  = resp_q;
        snoop_resp_o.cd_valid = (state == S_DATA);
        snoop_resp_o.cd.data  = line_q[int'(beat_q)*DataWidth +: DataWidth];
        snoop_resp_o.cd.last  = (state == S_DATA) && beat_last;
        lookup_req_o          = (state == S_LOOKUP);
        update_req_o          = (state == S_UPDATE);
        update_op_o           = (state == S_UPDATE) ? op_q : UPD_NONE;
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Bench for ace_snoop_responder: directed snoops against a behavioural
// response model, a negedge monitor that scoreboards every CR/CD/update
// handshake and checks payload stability under random stalls.
module tb_ace_snoop_responder;
    import ace_pkg::*;

    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snoop_req_t  req;
    snoop_resp_t resp;
    logic        lookup_req, lookup_gnt, lookup_valid;
    logic        lk_hit, lk_dirty, lk_shared;
    logic [511:0] lk_data;
    logic [63:0] lookup_addr;
    logic        update_req, update_gnt;
    logic [1:0]  update_op;

    ace_snoop_responder dut (
        .clk_i(clk), .rst_i(rst),
        .snoop_req_i(req), .snoop_resp_o(resp),
        .lookup_req_o(lookup_req), .lookup_gnt_i(lookup_gnt),
        .lookup_addr_o(lookup_addr), .lookup_valid_i(lookup_valid),
        .lookup_hit_i(lk_hit), .lookup_dirty_i(lk_dirty),
        .lookup_shared_i(lk_shared), .lookup_data_i(lk_data),
        .update_req_o(update_req), .update_gnt_i(update_gnt),
        .update_op_o(update_op)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {update_op, cr_resp} for a snoop, straight from the rule table.
    function automatic logic [6:0] model(input logic [3:0] s, input logic h, d, sh);
        logic dt, pd, is_sh, known;
        logic [1:0] op;
        known = 1; dt = 0; pd = 0; is_sh = 0; op = 0;
        case (s)
            4'b0000: begin dt = 1; is_sh = 1; end
            4'b0001, 4'b0010, 4'b0011: begin dt = 1; pd = d; is_sh = 1; op = 2; end
            4'b0111: begin dt = 1; pd = d; op = 3; end
            4'b1000: begin dt = d; pd = d; is_sh = d | sh; op = d ? 2'd1 : 2'd0; end
            4'b1001: begin dt = d; pd = d; op = 3; end
            4'b1101: op = 3;
            default: known = 0;
        endcase
        if (!h || !known) return 7'd0;
        return {op, h & ~sh, is_sh, pd, 1'b0, dt};
    endfunction

    // Environment knobs set by the stimulus
    logic         stall_en = 0;
    logic [511:0] t_line = '0;
    logic         t_hit = 0, t_dirty = 0, t_shared = 0;

    // Monitor / scoreboard state
    logic         in_flight = 0, lk_pend = 0, upd_seen = 0, cr_first = 0, rdy_next = 0;
    logic [4:0]   e_resp = 0, got_resp = 0;
    logic [1:0]   e_op = 0, got_op = 0;
    logic [63:0]  e_addr = 0;
    logic [511:0] e_line = '0;
    int           beat_cnt = 0, got_beats = 0, done_cnt = 0, cyc = 0, ac_cyc = 0, cr_lat = 0;
    logic         p_cr = 0, p_cd = 0, p_lk = 0, p_up = 0;
    logic [4:0]   p_cr_resp = 0;
    logic [64:0]  p_cd_pl = 0;
    logic [63:0]  p_lk_addr = 0;
    logic [1:0]   p_up_op = 0;

    // Input driver: ready/grant (optionally random) and one-cycle lookup result
    initial begin
        lookup_valid = 0; lookup_gnt = 1; update_gnt = 1;
        lk_hit = 0; lk_dirty = 0; lk_shared = 0; lk_data = '0;
        forever begin
            @(posedge clk); #1;
            lookup_valid = lk_pend;
            lk_pend      = 0;
            lk_hit = t_hit; lk_dirty = t_dirty; lk_shared = t_shared; lk_data = t_line;
            req.cr_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            req.cd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            lookup_gnt   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            update_gnt   = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every cycle, sampled on the falling edge
    initial begin
        logic [6:0] m;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                in_flight = 0; lk_pend = 0; rdy_next = 0;
                p_cr = 0; p_cd = 0; p_lk = 0; p_up = 0;
            end else begin
                if (p_cr) begin
                    chk("cr_hold_valid", resp.cr_valid, 1);
                    chk("cr_hold_resp", resp.cr_resp, p_cr_resp);
                end
                if (p_cd) begin
                    chk("cd_hold_valid", resp.cd_valid, 1);
                    chk("cd_hold_payload", {resp.cd.data, resp.cd.last}, p_cd_pl);
                end
                if (p_lk) chk("lookup_hold", {lookup_req, lookup_addr}, {1'b1, p_lk_addr});
                if (p_up) chk("update_hold", {update_req, update_op}, {1'b1, p_up_op});
                if (rdy_next) chk("ac_ready_after_end", resp.ac_ready, 1);
                rdy_next = 0;
                if (!in_flight)
                    chk("idle_outputs", {resp.cr_valid, resp.cd_valid, lookup_req, update_req}, 0);
                else
                    chk("ac_ready_busy", resp.ac_ready, 0);

                if (resp.ac_ready && req.ac_valid) begin
                    m = model(req.ac.snoop, t_hit, t_dirty, t_shared);
                    e_resp = m[4:0]; e_op = m[6:5];
                    e_addr = req.ac.addr & ~64'h3f;
                    e_line = t_line;
                    in_flight = 1; beat_cnt = 0; upd_seen = 0; cr_first = 1;
                    got_op = 0; got_beats = 0; ac_cyc = cyc;
                end else if (in_flight) begin
                    if (lookup_req) chk("lookup_addr", lookup_addr, e_addr);
                    if (lookup_req && lookup_gnt) lk_pend = 1;
                    if (update_req && update_gnt) begin
                        chk("update_op", update_op, e_op);
                        upd_seen = 1; got_op = update_op;
                    end
                    if (resp.cr_valid && cr_first) begin
                        cr_lat = cyc - ac_cyc; cr_first = 0;
                    end
                    if (resp.cr_valid && req.cr_ready) begin
                        chk("cr_resp", resp.cr_resp, e_resp);
                        chk("update_done", upd_seen, e_op != 0);
                        got_resp = resp.cr_resp;
                        if (!e_resp[0]) begin
                            in_flight = 0; done_cnt++; rdy_next = 1;
                        end
                    end
                    if (resp.cd_valid) chk("cd_needs_dt", e_resp[0], 1);
                    if (resp.cd_valid && req.cd_ready) begin
                        chk("cd_data", resp.cd.data, e_line[beat_cnt*64 +: 64]);
                        chk("cd_last", resp.cd.last, beat_cnt == NB - 1);
                        beat_cnt++; got_beats = beat_cnt;
                        if (beat_cnt >= NB) begin
                            in_flight = 0; done_cnt++; rdy_next = 1;
                        end
                    end
                end
                p_cr = resp.cr_valid && !req.cr_ready;  p_cr_resp = resp.cr_resp;
                p_cd = resp.cd_valid && !req.cd_ready;  p_cd_pl   = {resp.cd.data, resp.cd.last};
                p_lk = lookup_req && !lookup_gnt;       p_lk_addr = lookup_addr;
                p_up = update_req && !update_gnt;       p_up_op   = update_op;
            end
        end
    end

    task automatic new_line();
        for (int i = 0; i < 16; i++) t_line[i*32 +: 32] = $urandom;
    endtask

    task automatic send_ac(input logic [3:0] snp, input logic [63:0] addr);
        int k;
        @(posedge clk); #1;
        req.ac_valid = 1; req.ac.addr = addr; req.ac.snoop = snp; req.ac.prot = 3'd0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (resp.ac_ready) break;
        end
        if (k == 200) begin
            total++; bad++; $display("FAIL ac_accept: got timeout expected handshake");
        end
        @(posedge clk); #1;
        req.ac_valid = 0;
    endtask

    task automatic run_snoop(input string nm, input logic [3:0] snp, input logic [63:0] addr,
                             input logic h, d, sh, input logic [4:0] x_resp,
                             input logic [1:0] x_op, input int x_lat);
        int d0, k;
        t_hit = h; t_dirty = d; t_shared = sh; new_line();
        chk({nm, "_model"}, model(snp, h, d, sh), {x_op, x_resp});
        d0 = done_cnt;
        send_ac(snp, addr);
        for (k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) break;
        end
        if (k == 400) begin
            total++; bad++; $display("FAIL %s_done: got timeout expected completion", nm);
        end
        chk({nm, "_resp"}, got_resp, x_resp);
        chk({nm, "_op"}, got_op, x_op);
        chk({nm, "_beats"}, got_beats, x_resp[0] ? NB : 0);
        if (x_lat >= 0) chk({nm, "_latency"}, cr_lat, x_lat);
    endtask

    initial begin
        int k;
        req = '0;
        req.cr_ready = 1; req.cd_ready = 1;
        #12;
        chk("rst_ac_ready", resp.ac_ready, 0);
        chk("rst_valids", {resp.cr_valid, resp.cd_valid, lookup_req, update_req}, 0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("idle_ac_ready", resp.ac_ready, 1);

        // Directed, no stalls
        run_snoop("rs_dirty",   4'b0001, 64'h1234_5678_9abc_def7, 1, 1, 1, 5'b01101, 2'd2, 4);
        run_snoop("mi_shared",  4'b1101, 64'h40,                  1, 0, 1, 5'b00000, 2'd3, 4);
        run_snoop("mi_unique",  4'b1101, 64'h80,                  1, 1, 0, 5'b10000, 2'd3, 4);
        run_snoop("ru_miss",    4'b0111, 64'hffff_0000_0000_003f, 0, 1, 0, 5'b00000, 2'd0, 3);
        run_snoop("cs_clean_u", 4'b1000, 64'h100,                 1, 0, 0, 5'b10000, 2'd0, 3);
        run_snoop("ro_unique",  4'b0000, 64'h2c0,                 1, 0, 0, 5'b11001, 2'd0, 3);
        run_snoop("ru_dirty",   4'b0111, 64'h300,                 1, 1, 0, 5'b10101, 2'd3, 4);
        run_snoop("ci_dirty",   4'b1001, 64'h340,                 1, 1, 1, 5'b00101, 2'd3, 4);
        run_snoop("cs_dirty_u", 4'b1000, 64'h380,                 1, 1, 0, 5'b11101, 2'd1, 4);
        run_snoop("unknown",    4'b0100, 64'h3c0,                 1, 1, 0, 5'b00000, 2'd0, 3);

        // Random stalls on every ready/grant
        stall_en = 1;
        run_snoop("st_rc",   4'b0010, 64'h1000, 1, 0, 1, 5'b01001, 2'd2, -1);
        run_snoop("st_rnsd", 4'b0011, 64'h1040, 1, 1, 0, 5'b11101, 2'd2, -1);
        run_snoop("st_ci",   4'b1001, 64'h1080, 1, 0, 0, 5'b10000, 2'd3, -1);
        run_snoop("st_ro",   4'b0000, 64'h10c0, 1, 1, 1, 5'b01001, 2'd0, -1);
        stall_en = 0;

        // Reset while beat 3 is on CD
        t_hit = 1; t_dirty = 1; t_shared = 0; new_line();
        send_ac(4'b0111, 64'h2000);
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (resp.cd_valid && beat_cnt == 3) break;
        end
        chk("reach_beat3", k < 100, 1);
        rst = 1; #1;
        chk("mid_rst_ac_ready", resp.ac_ready, 0);
        chk("mid_rst_valids", {resp.cr_valid, resp.cd_valid, lookup_req, update_req}, 0);
        chk("mid_rst_cd", {resp.cd.data, resp.cd.last, resp.cr_resp, update_op}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (3) @(negedge clk);
        run_snoop("post_rst", 4'b0001, 64'h2040, 1, 0, 0, 5'b11001, 2'd2, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
